// File: rtl/count_pkg.sv
// Shared defaults, count type and next-operation encoding for the modulo up/down counter.
package count_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_MOD    = 12;
    localparam int DEF_WRAP_W = 8;

    typedef logic [DEF_WIDTH-1:0] count_t;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } op_t;

endpackage

// File: rtl/sat_event_counter.sv
// Saturating event counter: counts i_inc pulses, sticks at all-ones, cleared by async reset.
module sat_event_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_count = r_cnt;

endmodule

// File: rtl/updown_mod_counter.sv
// Loadable modulo-MOD up/down counter with terminal-count pulse, saturating wrap
// counter and a sticky flag for out-of-range loads.
module updown_mod_counter
    import count_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int MOD    = DEF_MOD,
    parameter int WRAP_W = DEF_WRAP_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              load,
    input  logic              up_down,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              load_err
);

    if (MOD < 2) begin : g_bad_mod
        $error("updown_mod_counter: MOD must be at least 2");
    end
    if ((2 ** WIDTH) < MOD) begin : g_bad_width
        $error("updown_mod_counter: WIDTH too narrow for MOD");
    end

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH:0]   ONE_EXT = (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_err;

    op_t              w_op;
    logic             w_legal;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;

    // Compare in WIDTH+1 bits so MOD == 2**WIDTH needs no special handling.
    assign w_legal = ({1'b0, data_in} < MOD_EXT);
    assign w_inc   = {1'b0, r_count} + ONE_EXT;
    assign w_dec   = r_count - WIDTH'(1);

    always_comb begin
        w_op = OP_HOLD;
        if (load) begin
            w_op = w_legal ? OP_LOAD : OP_HOLD;
        end else if (up_down) begin
            w_op = OP_INC;
        end else begin
            w_op = OP_DEC;
        end
    end

    always_comb begin
        w_next = r_count;
        w_wrap = 1'b0;
        unique case (w_op)
            OP_LOAD: w_next = data_in;
            OP_INC: begin
                if (w_inc == MOD_EXT) begin
                    w_next = '0;
                    w_wrap = 1'b1;
                end else begin
                    w_next = w_inc[WIDTH-1:0];
                end
            end
            OP_DEC: begin
                if (r_count == '0) begin
                    w_next = LAST;
                    w_wrap = 1'b1;
                end else begin
                    w_next = w_dec;
                end
            end
            default: w_next = r_count;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_next;
            r_tc    <= w_wrap;
            if (load && !w_legal) begin
                r_err <= 1'b1;
            end
        end
    end

    sat_event_counter #(
        .W(WRAP_W)
    ) u_wrap_cnt (
        .i_clk   (clock),
        .i_rst_n (resetn),
        .i_inc   (w_wrap),
        .o_count (wrap_cnt)
    );

    assign count    = r_count;
    assign tc       = r_tc;
    assign load_err = r_err;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: driver pushes model predictions, monitor pops and compares after each edge.
module tb_updown_mod_counter;

    localparam int WIDTH = 4;
    localparam int MOD   = 12;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             load = 1'b0;
    logic             up_down = 1'b1;

    logic [WIDTH-1:0] count_a, count_b;
    logic             tc_a, tc_b, err_a, err_b;
    logic [7:0]       wrap_a;
    logic [1:0]       wrap_b;

    updown_mod_counter #(.WIDTH(WIDTH), .MOD(MOD), .WRAP_W(8)) dut_a (
        .clock(clock), .resetn(resetn), .data_in(data_in), .load(load), .up_down(up_down),
        .count(count_a), .tc(tc_a), .wrap_cnt(wrap_a), .load_err(err_a)
    );

    updown_mod_counter #(.WIDTH(WIDTH), .MOD(MOD), .WRAP_W(2)) dut_b (
        .clock(clock), .resetn(resetn), .data_in(data_in), .load(load), .up_down(up_down),
        .count(count_b), .tc(tc_b), .wrap_cnt(wrap_b), .load_err(err_b)
    );

    always #5 clock = ~clock;

    typedef struct {
        int count;
        int tc;
        int wraps8;
        int wraps2;
        int err;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    int m_count, m_wraps, m_err;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference model: modular arithmetic over plain integers.
    task automatic step(input bit ld, input int d, input bit up);
        exp_t e;
        int   raw;
        bit   wrapped;
        @(negedge clock);
        resetn  = 1'b1;
        load    = ld;
        data_in = d[WIDTH-1:0];
        up_down = up;
        wrapped = 1'b0;
        if (ld) begin
            if (d < MOD) m_count = d;
            else         m_err = 1;
        end else begin
            raw     = m_count + (up ? 1 : -1);
            wrapped = (raw < 0) || (raw >= MOD);
            m_count = (raw + MOD) % MOD;
        end
        if (wrapped) m_wraps++;
        e.count  = m_count;
        e.tc     = int'(wrapped);
        e.wraps8 = min_i(m_wraps, 255);
        e.wraps2 = min_i(m_wraps, 3);
        e.err    = m_err;
        q.push_back(e);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clock);
        #2;
        resetn  = 1'b0;
        m_count = 0;
        m_wraps = 0;
        m_err   = 0;
        #1;
        check({tag, "_count"}, int'(count_a), 0);
        check({tag, "_tc"}, int'(tc_a), 0);
        check({tag, "_wrap"}, int'(wrap_a), 0);
        check({tag, "_err"}, int'(err_a), 0);
        check({tag, "_wrap2"}, int'(wrap_b), 0);
        @(negedge clock);
        check({tag, "_hold_count"}, int'(count_a), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("count", int'(count_a), e.count);
                check("tc", int'(tc_a), e.tc);
                check("wrap_cnt", int'(wrap_a), e.wraps8);
                check("load_err", int'(err_a), e.err);
                check("count_w2", int'(count_b), e.count);
                check("tc_w2", int'(tc_b), e.tc);
                check("wrap_cnt_w2", int'(wrap_b), e.wraps2);
                check("load_err_w2", int'(err_b), e.err);
            end
            if (resetn) check("count_lt_mod", int'(count_a < MOD), 1);
        end
    end

    initial begin : driver
        int r;
        m_count = 0;
        m_wraps = 0;
        m_err   = 0;
        #1;
        check("por_count", int'(count_a), 0);
        check("por_err", int'(err_a), 0);

        // Reset then up-count through a wrap.
        apply_reset("rst1");
        for (int i = 0; i < 13; i++) step(1'b0, 0, 1'b1);

        // Down wrap from a loaded value.
        step(1'b1, 2, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0);

        // Direction flip at zero wraps immediately.
        step(1'b1, 0, 1'b1);
        step(1'b0, 0, 1'b0);

        // Illegal load holds count and sets the sticky flag; legal load follows.
        step(1'b1, 5, 1'b1);
        step(1'b1, 13, 1'b1);
        step(1'b1, 3, 1'b0);
        step(1'b0, 9, 1'b1);

        // Load has priority and never produces tc, even onto the wrap target.
        step(1'b1, 11, 1'b0);
        step(1'b1, 0, 1'b1);
        step(1'b1, 11, 1'b1);
        step(1'b1, 11, 1'b1);

        // Async reset mid-count, then resume from 0.
        step(1'b1, 5, 1'b1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        apply_reset("rst_mid");
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);

        // Saturation of the narrow wrap counter across five wraps.
        for (int i = 0; i < 5 * MOD; i++) step(1'b0, 0, 1'b1);

        // Randomised traffic including out-of-range loads and occasional resets.
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                apply_reset("rst_rand");
            end else if (r < 20) begin
                step(1'b1, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end else if (r < 60) begin
                step(1'b0, int'($urandom_range(0, 15)), 1'b1);
            end else begin
                step(1'b0, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
        end

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
        check("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
